uart_tx_mmio: RTL
=================

# uart_tx_mmio

Memory-mapped UART transmitter sitting directly downstream of the CPU's store path: it decodes CPU stores to two fixed addresses, buffers outgoing bytes in a small FIFO, and serialises them onto a single `txd` line as 8N1 frames. The CPU reads status (empty/full/overflow/busy) from the same block through a combinational read port, so software can poll before writing.

## Interface
- `CLK_DIV`, 868: clock cycles per UART bit; legal range ≥ 2.
- `FIFO_DEPTH`, 8: byte FIFO entries; power of two, ≥ 2.
- `TX_ADDR`, 32'h0000_F000: store here pushes `wdata[7:0]`.
- `STAT_ADDR`, 32'h0000_F004: status register address.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `we`  in  1  CPU store strobe, one transfer per asserted cycle.
- `addr`  in  32  CPU data address (full-word compare, no masking).
- `wdata`  in  32  CPU store data.
- `rdata`  out  32  status read: {28'b0, busy, overflow, full, empty}; combinational from `addr`, 0 when `addr` ≠ `STAT_ADDR`.
- `txd`  out  1  serial output, idle high.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Push: `we`=1 and `addr`=`TX_ADDR` writes `wdata[7:0]` at the FIFO write pointer; count +1.
- Push while full: byte dropped, `overflow` set (sticky). Exception: if the FSM pops in the same cycle, push is accepted and count is unchanged.
- Clear: `we`=1, `addr`=`STAT_ADDR`, `wdata[2]`=1 clears `overflow`. Other bits ignored. A simultaneous overflow event wins (flag stays 1).
- Stores to any other address are ignored.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `txd`=1. If FIFO non-empty, pop into shift register, reset bit timer, go START.
  - START: `txd`=0 for `CLK_DIV` cycles, then DATA with bit index 0.
  - DATA: `txd`=shift[0]; each `CLK_DIV` cycles shift right, index +1; after bit 7 go STOP (or PARITY, see Configuration).
  - STOP: `txd`=1 for `CLK_DIV` cycles. At its end, if FIFO non-empty pop and go directly to START (no idle bit); else IDLE.
- Bit timer: counter 0..`CLK_DIV`-1, width $clog2(`CLK_DIV`); bit ends when counter = `CLK_DIV`-1.
- FIFO pointers $clog2(`FIFO_DEPTH`) bits, wrap naturally; count has one extra bit. `empty` = count==0, `full` = count==`FIFO_DEPTH`.
- `txd` is driven from a register (glitch-free).

## Timing
- Reset (async, any state, mid-frame included): FSM IDLE, `txd`=1, `busy`=0, pointers/count 0, `overflow`=0, timer 0; `rdata` reads 32'h1 at `STAT_ADDR`. The partially sent frame is abandoned and FIFO contents discarded.
- Push at edge N: `empty`=0 after N. Edge N+1: pop, START; `txd` low and `busy`=1 from N+1.
- Frame length: 10·`CLK_DIV` cycles (11·`CLK_DIV` with parity); back-to-back frames have no gap.
- Status reflects registered state; a push at edge N is visible in `rdata` from cycle after N.
- `busy` deasserts on the edge ending the last STOP bit with FIFO empty.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state inserted between DATA and STOP; `txd` = even parity (XOR of the 8 data bits) for `CLK_DIV` cycles; frame becomes 8E1, 11 bits.
- Undefined: no PARITY state, 8N1, 10-bit frame; no parity logic synthesised.

## Test plan
- Reset: `CLK_DIV`=4; assert `rst` mid-DATA -> `txd`=1, `busy`=0, `rdata`=32'h1 at `STAT_ADDR` immediately, without a clock edge.
- Single byte: store 32'h0000_00A5 to `TX_ADDR` -> `txd` low 4 cycles from next edge, then 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles; `busy` high exactly 40 cycles.
- Back-to-back: push 8'h55 and 8'h0F on consecutive cycles -> second start bit begins the cycle after the first stop bit ends; 80 busy cycles total.
- Overflow: `FIFO_DEPTH`=4, FSM busy; push 6 bytes -> `full`=1 and `overflow`=1 (rdata 32'hE); write 32'h4 to `STAT_ADDR` -> `overflow`=0, only the first 5 bytes (1 in flight + 4 buffered) appear on `txd`.
- Push with simultaneous pop while full: push lands on the STOP-end edge -> accepted, count stays 4, `overflow` stays 0.
- Parity (`UART_TX_PARITY_EN`): send 8'h07 -> parity bit 1, frame 44 cycles; send 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with byte FIFO; define UART_TX_PARITY_EN for 8E1
module uart_tx_mmio #(
    parameter int          CLK_DIV    = 868,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [31:0] TX_ADDR    = 32'h0000_F000,
    parameter logic [31:0] STAT_ADDR  = 32'h0000_F004
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        txd,
    output logic        busy
);

    localparam int TW = $clog2(CLK_DIV);
    localparam int PW = $clog2(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            txd_q, txd_d;
`ifdef UART_TX_PARITY_EN
    logic            par_q, par_d;
`endif

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW:0]     count_q;
    logic            overflow_q;

    logic            empty, full, pop, bit_end;
    logic            push_req, push_ok, ovf_ev, clr_ovf;
    logic [7:0]      head;
    logic            unused_wdata;

    assign unused_wdata = ^{wdata[31:8], wdata[1:0]};

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PW+1)'(FIFO_DEPTH));
    assign head     = fifo_mem[rd_ptr_q];
    assign bit_end  = (timer_q == TW'(CLK_DIV - 1));

    // A push into a full FIFO is still accepted when the FSM frees a slot on the same edge.
    assign push_req = we && (addr == TX_ADDR);
    assign push_ok  = push_req && (!full || pop);
    assign ovf_ev   = push_req && full && !pop;
    assign clr_ovf  = we && (addr == STAT_ADDR) && wdata[2];

    assign busy  = (state_q != S_IDLE);
    assign txd   = txd_q;

    // Status read port is purely combinational from the address.
    always_comb begin
        rdata = '0;
        if (addr == STAT_ADDR)
            rdata = {28'b0, busy, overflow_q, full, empty};
    end

    // FIFO storage; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (push_ok)
            fifo_mem[wr_ptr_q] <= wdata[7:0];
    end

    // FIFO pointers, occupancy and the sticky overflow flag (set beats clear).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)
                rd_ptr_q <= rd_ptr_q + PW'(1);
            if (push_ok && !pop)
                count_q <= count_q + (PW+1)'(1);
            else if (!push_ok && pop)
                count_q <= count_q - (PW+1)'(1);
            if (ovf_ev)
                overflow_q <= 1'b1;
            else if (clr_ovf)
                overflow_q <= 1'b0;
        end
    end

    // Frame sequencer: next state, bit timer, shifter and the next txd level.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = head;
                    timer_d = '0;
                    state_d = S_START;
`ifdef UART_TX_PARITY_EN
                    par_d   = ^head;
`endif
                end
            end
            S_START: begin
                if (bit_end) begin
                    timer_d = '0;
                    idx_d   = 3'd0;
                    state_d = S_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    state_d = S_STOP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            S_STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        shift_d = head;
                        state_d = S_START;
`ifdef UART_TX_PARITY_EN
                        par_d   = ^head;
`endif
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // txd is registered from the level of the state being entered.
        txd_d = 1'b1;
        case (state_d)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: txd_d = par_d;
`endif
            default:  txd_d = 1'b1;
        endcase
    end

    // Sequencer registers; reset abandons any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            txd_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule
